// File: rtl/div_result_bcd.sv
// Converts the divider's binary quotient/remainder into packed BCD with a
// one-bit-per-cycle double-dabble, holding each result until it is acknowledged.
module div_result_bcd_lane #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cap,
    input  logic                  i_step,
    input  logic [WIDTH-1:0]      i_bin,
    output logic [4*DIGITS-1:0]   o_next
);
    logic [WIDTH-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_sc;
    logic [4*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_sc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_sc[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_sc[4*d +: 4] + 4'd3;
        end
    end

    // Adjusted scratch shifted left, binary MSB entering at the bottom.
    assign o_next = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin <= '0;
            r_sc  <= '0;
        end else if (i_cap) begin
            r_bin <= i_bin;
            r_sc  <= '0;
        end else if (i_step) begin
            r_bin <= {r_bin[WIDTH-2:0], 1'b0};
            r_sc  <= o_next;
        end
    end
endmodule

module div_result_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done,
    input  logic [WIDTH-1:0]      Quotient,
    input  logic [WIDTH-1:0]      Remainder,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  valid,
    output logic                  busy,
    output logic                  overrun
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] r_state;
    logic [4:0] r_cnt;

    logic [1:0][WIDTH-1:0]    w_bin;
    logic [1:0][4*DIGITS-1:0] w_next;
    logic w_start, w_step, w_last, w_drop;

    assign w_bin   = {Remainder, Quotient};
    assign w_start = done && (r_state == IDLE || (r_state == HOLD && ack));
    assign w_step  = (r_state == CONV);
    assign w_last  = w_step && (r_cnt == 5'(WIDTH - 1));
    assign w_drop  = done && (r_state == CONV || (r_state == HOLD && !ack));
    assign busy    = (r_state != IDLE);

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lane
            div_result_bcd_lane #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .i_cap  (w_start),
                .i_step (w_step),
                .i_bin  (w_bin[g]),
                .o_next (w_next[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            q_bcd   <= '0;
            r_bcd   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (w_drop) overrun <= 1'b1;
            if (w_start) begin
                r_state <= CONV;
                r_cnt   <= '0;
                valid   <= 1'b0;
            end else if (w_last) begin
                r_state <= HOLD;
                q_bcd   <= w_next[0];
                r_bcd   <= w_next[1];
                valid   <= 1'b1;
            end else if (w_step) begin
                r_cnt   <= r_cnt + 5'd1;
            end else if (r_state == HOLD && ack) begin
                r_state <= IDLE;
                valid   <= 1'b0;
            end
        end
    end
endmodule
